// File: rtl/key_input_decoder_pkg.sv
// Shared game constants: key codes, instruction bit positions and decoder FSM encoding.
// Used by the key decoder, Player and Machine blocks.
package key_input_decoder_pkg;

  localparam logic [7:0] KEY_ESC      = 8'h1B;
  localparam logic [7:0] KEY_LBRACKET = 8'h5B;
  localparam logic [7:0] KEY_SPACE    = 8'h20;
  localparam logic [7:0] KEY_ENTER    = 8'h0D;
  localparam logic [7:0] KEY_W_LO     = 8'h77;
  localparam logic [7:0] KEY_W_UP     = 8'h57;
  localparam logic [7:0] KEY_S_LO     = 8'h73;
  localparam logic [7:0] KEY_S_UP     = 8'h53;
  localparam logic [7:0] KEY_A_LO     = 8'h61;
  localparam logic [7:0] KEY_A_UP     = 8'h41;
  localparam logic [7:0] KEY_D_LO     = 8'h64;
  localparam logic [7:0] KEY_D_UP     = 8'h44;
  localparam logic [7:0] KEY_J_LO     = 8'h6A;
  localparam logic [7:0] KEY_J_UP     = 8'h4A;
  localparam logic [7:0] KEY_X_LO     = 8'h78;
  localparam logic [7:0] KEY_X_UP     = 8'h58;
  localparam logic [7:0] ARROW_UP     = 8'h41;
  localparam logic [7:0] ARROW_DOWN   = 8'h42;
  localparam logic [7:0] ARROW_RIGHT  = 8'h43;
  localparam logic [7:0] ARROW_LEFT   = 8'h44;

  localparam int INSTR_UP     = 0;
  localparam int INSTR_DOWN   = 1;
  localparam int INSTR_LEFT   = 2;
  localparam int INSTR_RIGHT  = 3;
  localparam int INSTR_ATTACK = 4;
  localparam int NUM_HELD     = 5;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ESC  = 2'd1,
    SEQ_CSI  = 2'd2
  } seq_state_t;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_UP      = 3'd1,
    CMD_DOWN    = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_RIGHT   = 3'd4,
    CMD_ATTACK  = 3'd5,
    CMD_CONFIRM = 3'd6,
    CMD_CANCEL  = 3'd7
  } cmd_t;

  // Single-byte commands accepted outside an escape sequence.
  function automatic cmd_t decode_plain(input logic [7:0] b);
    cmd_t c;
    case (b)
      KEY_W_LO, KEY_W_UP:   c = CMD_UP;
      KEY_S_LO, KEY_S_UP:   c = CMD_DOWN;
      KEY_A_LO, KEY_A_UP:   c = CMD_LEFT;
      KEY_D_LO, KEY_D_UP:   c = CMD_RIGHT;
      KEY_J_LO, KEY_J_UP:   c = CMD_ATTACK;
      KEY_SPACE, KEY_ENTER: c = CMD_CONFIRM;
      KEY_X_LO, KEY_X_UP:   c = CMD_CANCEL;
      default:              c = CMD_NONE;
    endcase
    return c;
  endfunction

  // Final byte of an ESC '[' arrow sequence.
  function automatic cmd_t decode_arrow(input logic [7:0] b);
    cmd_t c;
    case (b)
      ARROW_UP:    c = CMD_UP;
      ARROW_DOWN:  c = CMD_DOWN;
      ARROW_RIGHT: c = CMD_RIGHT;
      ARROW_LEFT:  c = CMD_LEFT;
      default:     c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_input_decoder_hold_counter.sv
// Per-key hold timer: reloads on key acceptance, counts down on game ticks,
// active is registered alongside the count so both change on the same edge.
module hold_counter #(
  parameter int HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       clear,
  input  logic       tick,
  output logic [3:0] count,
  output logic       active
);

  localparam logic [3:0] HOLD_VAL = 4'(HOLD_TICKS);

  logic [3:0] count_d, count_q;
  logic       active_d, active_q;

  // A reload always beats both the opposite-key clear and the tick decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = HOLD_VAL;
    end else if (clear) begin
      count_d = 4'd0;
    end else if (tick && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
    active_d = (count_d != 4'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 4'd0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign count  = count_q;
  assign active = active_q;

endmodule

// File: rtl/key_input_decoder.sv
// UART key byte decoder: letter keys and ESC '[' arrow sequences become held
// direction/attack bits, confirm/cancel pulses, last-key and error bookkeeping.
module key_input_decoder
  import key_input_decoder_pkg::*;
#(
  parameter int HOLD_TICKS = 3,
  parameter int SEQ_TICKS  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tick,
  output logic [15:0] player_instr,
  output logic        confirm_pulse,
  output logic        cancel_pulse,
  output logic [7:0]  key_last,
  output logic [7:0]  err_count
);

  localparam logic [1:0] SEQ_VAL = 2'(SEQ_TICKS);

  seq_state_t state_d, state_q;
  logic [1:0] seq_timer_d, seq_timer_q;
  logic       confirm_d, confirm_q;
  logic       cancel_d, cancel_q;
  logic [7:0] key_last_d, key_last_q;
  logic [7:0] err_count_d, err_count_q;

  cmd_t                     cmd;
  logic                     reject;
  logic [NUM_HELD-1:0]      load;
  logic [NUM_HELD-1:0]      clear_req;
  logic [NUM_HELD-1:0]      held;
  logic [NUM_HELD-1:0][3:0] hold_count;

  always_comb begin
    state_d     = state_q;
    seq_timer_d = seq_timer_q;
    cmd         = CMD_NONE;
    reject      = 1'b0;
    if (rx_valid) begin
      case (state_q)
        SEQ_IDLE: begin
          if (rx_data == KEY_ESC) begin
            state_d     = SEQ_ESC;
            seq_timer_d = SEQ_VAL;
          end else begin
            cmd    = decode_plain(rx_data);
            reject = (cmd == CMD_NONE);
          end
        end
        SEQ_ESC: begin
          if (rx_data == KEY_LBRACKET) begin
            state_d = SEQ_CSI;
          end else begin
            state_d = SEQ_IDLE;
            reject  = 1'b1;
          end
        end
        SEQ_CSI: begin
          state_d = SEQ_IDLE;
          cmd     = decode_arrow(rx_data);
          reject  = (cmd == CMD_NONE);
        end
        default: state_d = SEQ_IDLE;
      endcase
    end else if (tick && (state_q != SEQ_IDLE)) begin
      // The sequence window spans ESC and CSI; a byte in the same cycle suppresses expiry.
      if (seq_timer_q <= 2'd1) begin
        state_d     = SEQ_IDLE;
        seq_timer_d = 2'd0;
        reject      = 1'b1;
      end else begin
        seq_timer_d = seq_timer_q - 2'd1;
      end
    end
  end

  always_comb begin
    load        = '0;
    clear_req   = '0;
    confirm_d   = 1'b0;
    cancel_d    = 1'b0;
    key_last_d  = key_last_q;
    err_count_d = err_count_q;
    if (cmd != CMD_NONE) begin
      key_last_d = rx_data;
    end
    case (cmd)
      CMD_UP:      begin load[INSTR_UP]    = 1'b1; clear_req[INSTR_DOWN]  = 1'b1; end
      CMD_DOWN:    begin load[INSTR_DOWN]  = 1'b1; clear_req[INSTR_UP]    = 1'b1; end
      CMD_LEFT:    begin load[INSTR_LEFT]  = 1'b1; clear_req[INSTR_RIGHT] = 1'b1; end
      CMD_RIGHT:   begin load[INSTR_RIGHT] = 1'b1; clear_req[INSTR_LEFT]  = 1'b1; end
      CMD_ATTACK:  load[INSTR_ATTACK] = 1'b1;
      CMD_CONFIRM: confirm_d = 1'b1;
      CMD_CANCEL:  cancel_d  = 1'b1;
      default:     ;
    endcase
    if (reject && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEQ_IDLE;
      seq_timer_q <= 2'd0;
      confirm_q   <= 1'b0;
      cancel_q    <= 1'b0;
      key_last_q  <= 8'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      seq_timer_q <= seq_timer_d;
      confirm_q   <= confirm_d;
      cancel_q    <= cancel_d;
      key_last_q  <= key_last_d;
      err_count_q <= err_count_d;
    end
  end

  // Clearing an already-idle counter is a no-op, so only request it when it holds a value.
  for (genvar i = 0; i < NUM_HELD; i++) begin : g_hold
    hold_counter #(
      .HOLD_TICKS (HOLD_TICKS)
    ) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load[i]),
      .clear   (clear_req[i] && (hold_count[i] != 4'd0)),
      .tick    (tick),
      .count   (hold_count[i]),
      .active  (held[i])
    );
  end

  assign player_instr  = {11'd0, held};
  assign confirm_pulse = confirm_q;
  assign cancel_pulse  = cancel_q;
  assign key_last      = key_last_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_key_input_decoder.sv
// Scoreboard bench for key_input_decoder: a lookup-table reference model predicts
// each cycle's outputs into a queue that an independent monitor drains and compares.
module tb_key_input_decoder;

  localparam int HOLD = 3;
  localparam int SEQ  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tick;
  logic [15:0] player_instr;
  logic        confirm_pulse;
  logic        cancel_pulse;
  logic [7:0]  key_last;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  key_input_decoder #(
    .HOLD_TICKS (HOLD),
    .SEQ_TICKS  (SEQ)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tick          (tick),
    .player_instr  (player_instr),
    .confirm_pulse (confirm_pulse),
    .cancel_pulse  (cancel_pulse),
    .key_last      (key_last),
    .err_count     (err_count)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic        conf;
    logic        canc;
    logic [7:0]  last;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: command tables, per-key hold time left, escape progress.
  int         plain_map[logic [7:0]];
  int         arrow_map[logic [7:0]];
  int         cnt[5];
  int         seq_len;
  int         seq_left;
  int         m_err;
  logic [7:0] m_last;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    seq_len  = 0;
    seq_left = 0;
    m_err    = 0;
    m_last   = 8'd0;
  endfunction

  // Command codes: 0 up, 1 down, 2 left, 3 right, 4 attack, 5 confirm, 6 cancel.
  function automatic void model_step(bit v, logic [7:0] b, bit t);
    int   c = -1;
    bit   rej = 0;
    int   ld = -1;
    exp_t e;
    if (v) begin
      if (seq_len == 0) begin
        if (b == 8'h1B) begin
          seq_len  = 1;
          seq_left = SEQ;
        end else if (plain_map.exists(b)) c = plain_map[b];
        else rej = 1;
      end else if (seq_len == 1) begin
        if (b == 8'h5B) seq_len = 2;
        else begin seq_len = 0; rej = 1; end
      end else begin
        seq_len = 0;
        if (arrow_map.exists(b)) c = arrow_map[b];
        else rej = 1;
      end
    end else if (t && seq_len != 0) begin
      seq_left--;
      if (seq_left == 0) begin seq_len = 0; rej = 1; end
    end
    if (c >= 0) begin
      m_last = b;
      if (c < 5) ld = c;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == ld) cnt[i] = HOLD;
      else if (ld >= 0 && ld < 4 && i == (ld ^ 1)) cnt[i] = 0;
      else if (t && cnt[i] > 0) cnt[i]--;
    end
    if (rej && m_err < 255) m_err++;
    e.instr = 16'd0;
    for (int i = 0; i < 5; i++) e.instr[i] = (cnt[i] != 0);
    e.conf = (c == 5);
    e.canc = (c == 6);
    e.last = m_last;
    e.err  = 8'(m_err);
    exp_q.push_back(e);
  endfunction

  task automatic drive(bit v, logic [7:0] b, bit t);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    tick     = t;
    model_step(v, b, t);
  endtask

  task automatic idle(int n, bit t);
    for (int i = 0; i < n; i++) drive(0, 8'h00, t);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_instr"}, 32'(player_instr), 32'd0);
    check({tag, "_conf"}, 32'(confirm_pulse), 32'd0);
    check({tag, "_canc"}, 32'(cancel_pulse), 32'd0);
    check({tag, "_last"}, 32'(key_last), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  // Asynchronous reset placed between clock edges; outputs must clear without a clock.
  task automatic pulse_reset(string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    tick     = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: one expected entry per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr", 32'(player_instr), 32'(e.instr));
        check("confirm", 32'(confirm_pulse), 32'(e.conf));
        check("cancel", 32'(cancel_pulse), 32'(e.canc));
        check("key_last", 32'(key_last), 32'(e.last));
        check("err_count", 32'(err_count), 32'(e.err));
      end
    end
  end

  logic [7:0] pool[] = '{8'h1B, 8'h1B, 8'h5B, 8'h5B, 8'h41, 8'h42, 8'h43, 8'h44,
                         8'h77, 8'h57, 8'h73, 8'h61, 8'h64, 8'h6A, 8'h4A, 8'h20,
                         8'h0D, 8'h78, 8'h58, 8'h71, 8'h00, 8'hFF};

  initial begin
    plain_map[8'h77] = 0; plain_map[8'h57] = 0;
    plain_map[8'h73] = 1; plain_map[8'h53] = 1;
    plain_map[8'h61] = 2; plain_map[8'h41] = 2;
    plain_map[8'h64] = 3; plain_map[8'h44] = 3;
    plain_map[8'h6A] = 4; plain_map[8'h4A] = 4;
    plain_map[8'h20] = 5; plain_map[8'h0D] = 5;
    plain_map[8'h78] = 6; plain_map[8'h58] = 6;
    arrow_map[8'h41] = 0; arrow_map[8'h42] = 1;
    arrow_map[8'h44] = 2; arrow_map[8'h43] = 3;
    model_reset();

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick     = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    // 'w' held for three ticks, clearing on the third
    drive(1, 8'h77, 0);
    idle(2, 0);
    repeat (3) begin drive(0, 8'h00, 1); idle(1, 0); end
    idle(2, 1);

    // opposite directions: later key wins
    drive(1, 8'h61, 0);
    drive(1, 8'h64, 0);
    idle(2, 0);
    idle(4, 1);

    // arrow right, then a broken ESC sequence
    drive(1, 8'h1B, 0); drive(1, 8'h5B, 0); drive(1, 8'h43, 0);
    idle(1, 0);
    drive(1, 8'h1B, 0); drive(1, 8'h41, 0);
    idle(1, 0);
    drive(1, 8'h77, 0);
    idle(4, 1);

    // ESC timeout, then 's' decodes from idle
    drive(1, 8'h1B, 0);
    idle(1, 1); idle(1, 0); idle(1, 1);
    drive(1, 8'h73, 0);
    idle(4, 1);

    // byte and expiry in the same cycle: the byte wins
    drive(1, 8'h1B, 0); idle(1, 1); drive(1, 8'h5B, 1); drive(1, 8'h42, 0);
    idle(4, 1);

    // reload coincident with tick, then confirm and cancel pulses
    drive(1, 8'h77, 0);
    drive(0, 8'h00, 1);
    drive(1, 8'h57, 1);
    idle(1, 0);
    idle(3, 1);
    drive(1, 8'h20, 0); idle(2, 0);
    drive(1, 8'h0D, 1); drive(1, 8'h58, 0); drive(1, 8'h6A, 0);
    idle(4, 1);

    // reset mid-CSI and mid-hold
    drive(1, 8'h64, 0);
    drive(1, 8'h1B, 0); drive(1, 8'h5B, 0);
    pulse_reset("midcsi");
    drive(1, 8'h41, 0);
    drive(1, 8'h64, 0);
    idle(4, 1);

    // saturation of the error counter
    for (int i = 0; i < 258; i++) drive(1, 8'h71, 0);
    drive(1, 8'h1B, 0); drive(1, 8'h00, 0);
    drive(1, 8'h71, 0);
    idle(1, 0);
    pulse_reset("sat");

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit         v = ($urandom_range(0, 2) == 0);
      bit         t = ($urandom_range(0, 5) == 0);
      logic [7:0] b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, pool.size() - 1)];
      if ($urandom_range(0, 599) == 0) pulse_reset("rand");
      else drive(v, b, t);
    end
    idle(3, 0);

    @(negedge clk);
    rx_valid = 1'b0;
    tick     = 1'b0;
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_input_decoder.md
KEY_INPUT_DECODER -- requirements
Module: key_input_decoder

Interface
REQ-001 Parameter HOLD_TICKS, default 3, is the number of tick pulses a direction stays asserted after its last key byte (range 1..15).
REQ-002 Parameter SEQ_TICKS, default 2, is the number of tick pulses allowed to complete an ESC arrow sequence (range 1..3).
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  received UART byte, valid only when rx_valid=1.
REQ-006 rx_valid  in  1  one-clk strobe per received byte.
REQ-007 tick  in  1  one-clk enable pulse at the 10 Hz game rate.
REQ-008 player_instr  out  16  instruction word to Player: [0] up, [1] down, [2] left, [3] right, [4] attack held, [15:5] zero.
REQ-009 confirm_pulse  out  1  one-clk pulse on space/enter.
REQ-010 cancel_pulse  out  1  one-clk pulse on 'x'/'X'.
REQ-011 key_last  out  8  last byte that decoded to a valid command.
REQ-012 err_count  out  8  saturating count of rejected bytes/sequences.

Function
REQ-013 Decoding: 'w'/'W' or ESC '[' 'A' = up; 's'/'S' or ESC '[' 'B' = down; 'd'/'D' or ESC '[' 'C' = right; 'a'/'A' or ESC '[' 'D' = left; 'j'/'J' = attack; 0x20/0x0D = confirm; 'x'/'X' = cancel.
REQ-014 Each of the five held bits has a 4-bit hold counter; the bit equals (counter != 0), registered, visible the cycle after the counter update.
REQ-015 Accepting a held key reloads its counter to HOLD_TICKS and clears the counter of the opposite direction (up/down, left/right); attack has no opposite.
REQ-016 On tick, every nonzero counter that is not being reloaded the same cycle decrements by 1; a reload on the same cycle wins.
REQ-017 confirm_pulse/cancel_pulse assert exactly one clk, the cycle after the accepting rx_valid.
REQ-018 Sequence FSM states: IDLE, ESC, CSI.
REQ-019 IDLE: 0x1B -> ESC, sequence timer loaded with SEQ_TICKS; other bytes decode per REQ-013 or are rejected.
REQ-020 ESC: '[' -> CSI; any other byte -> IDLE, rejected (byte discarded, not re-decoded).
REQ-021 CSI: 'A'..'D' -> direction per REQ-013, -> IDLE; any other byte -> IDLE, rejected.
REQ-022 In ESC/CSI, tick decrements the sequence timer; reaching 0 -> IDLE, rejected; a byte and the timer expiry in the same cycle: the byte is processed, the expiry is ignored.
REQ-023 A rejected event increments err_count by 1, saturating at 255; key_last is unchanged.
REQ-024 key_last updates on acceptance: letter byte itself, or the final 'A'..'D' for arrow sequences.
REQ-025 Bytes with rx_valid=0 are ignored; no byte is ever queued (at most one byte per cycle by construction).

Reset
REQ-026 reset_n low asynchronously clears all counters, FSM to IDLE, player_instr=0, pulses=0, key_last=0, err_count=0.
REQ-027 Reset asserted mid-sequence or mid-hold discards that state; the first byte after release is decoded from IDLE.

Structure
REQ-028 Key code constants (ASCII values, ESC, '['), instruction bit indices and FSM state encoding belong in the shared game package used by Player and Machine.
REQ-029 One sub-module, hold_counter (load, tick, count, active), instantiated five times; FSM and decode stay in the top block.

Verification
REQ-030 HOLD_TICKS=3: byte 'w', then 3 ticks -> player_instr[0]=1 until the 3rd tick, then 0 the next cycle.
REQ-031 Bytes 'a' then 'd' within one tick -> [2]=0, [3]=1; key_last=0x64.
REQ-032 Bytes 0x1B,0x5B,0x43 -> [3]=1, key_last=0x43, err_count unchanged; 0x1B,0x41 -> no direction, err_count+1, FSM IDLE.
REQ-033 0x1B then 2 ticks with no byte -> FSM IDLE, err_count+1; the following 's' sets [1]=1.
REQ-034 'w' held with rx_valid and tick in the same cycle -> counter stays at 3; 0x20 -> confirm_pulse high exactly 1 cycle.
REQ-035 err_count at 255 plus a rejected byte 'q' -> stays 255; reset_n pulsed low mid-CSI -> all outputs 0 immediately, next 'd' decodes normally.
